// File: rtl/dmem_pkg.sv
// Shared definitions for the sized data memory: access-size encodings,
// FSM states and the byte-lane mask helper.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } dmemState_t;

    // Lanes touched by an access; size 11 behaves as a word.
    function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] addrLow);
        logic [3:0] mask;
        case (size)
            SIZE_BYTE: mask = 4'b0001 << addrLow;
            SIZE_HALF: mask = addrLow[1] ? 4'b1100 : 4'b0011;
            default:   mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: load extraction with sign/zero extension,
// and store data replication with byte-enable generation.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        unsignedLoad,
    input  logic [31:0] readWord,
    input  logic [31:0] writeData,
    output logic [31:0] loadData_c,
    output logic [31:0] storeWord_c,
    output logic [3:0]  byteEn_c
);

    logic [31:0] shifted;

    always_comb begin
        shifted    = readWord >> {offset, 3'b000};
        loadData_c = readWord;
        case (size)
            SIZE_BYTE: loadData_c = {{24{~unsignedLoad & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: loadData_c = {{16{~unsignedLoad & shifted[15]}}, shifted[15:0]};
            default:   loadData_c = readWord;
        endcase
    end

    // Replicate narrow store data across the word; byte enables pick the lanes.
    always_comb begin
        storeWord_c = writeData;
        case (size)
            SIZE_BYTE: storeWord_c = {4{writeData[7:0]}};
            SIZE_HALF: storeWord_c = {2{writeData[15:0]}};
            default:   storeWord_c = writeData;
        endcase
        byteEn_c = laneMask(size, offset);
    end

endmodule

// File: rtl/sized_data_memory.sv
// MEM-stage data memory with byte/half/word access and configurable read latency.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses instead of forcing alignment.
module sized_data_memory
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    output logic [31:0] ReadData,
    output logic        ReadValid,
    output logic        Busy,
    output logic        Misaligned
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 3;

    logic [31:0] mem [DEPTH_WORDS];

    dmemState_t state;
    dmemState_t nextState;
    logic [CNT_W-1:0] count;

    logic [IDX_W-1:0] liveIdx;
    logic [1:0]       liveOffset;
    logic             liveMis;
    logic             unusedAddrBits;

    logic [IDX_W-1:0] ldIdx;
    logic [1:0]       ldOffset;
    logic [1:0]       ldSize;
    logic             ldUnsigned;
    logic             ldMis;

    logic [IDX_W-1:0] selIdx;
    logic [1:0]       selOffset;
    logic [1:0]       selSize;
    logic             selUnsigned;
    logic             selMis;

    logic        reqLoad;
    logic        presentLoad;
    logic        storeEn;
    logic        storeMis;
    logic [31:0] loadData_c;
    logic [31:0] storeWord_c;
    logic [3:0]  byteEn_c;

    assign liveIdx        = Address[IDX_W+1:2];
    assign unusedAddrBits = ^Address[31:IDX_W+2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign liveOffset = Address[1:0];
    assign liveMis    = (Size == SIZE_BYTE) ? 1'b0 :
                        (Size == SIZE_HALF) ? Address[0] : (Address[1:0] != 2'b00);
`else
    // Forced alignment: drop the low address bits the access size cannot use.
    assign liveOffset = (Size == SIZE_BYTE) ? Address[1:0] :
                        (Size == SIZE_HALF) ? {Address[1], 1'b0} : 2'b00;
    assign liveMis    = 1'b0;
`endif

    assign reqLoad = (state == IDLE) && MemRead && !MemWrite;

    // A load finishing in IDLE (LATENCY=1) uses the live request, otherwise the latched one.
    always_comb begin
        selIdx      = ldIdx;
        selOffset   = ldOffset;
        selSize     = ldSize;
        selUnsigned = ldUnsigned;
        selMis      = ldMis;
        if (state == IDLE) begin
            selIdx      = liveIdx;
            selOffset   = liveOffset;
            selSize     = Size;
            selUnsigned = Unsigned;
            selMis      = liveMis;
        end
    end

    dmem_lane_align uLaneAlign (
        .size        (selSize),
        .offset      (selOffset),
        .unsignedLoad(selUnsigned),
        .readWord    (mem[selIdx]),
        .writeData   (WriteData),
        .loadData_c  (loadData_c),
        .storeWord_c (storeWord_c),
        .byteEn_c    (byteEn_c)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (reqLoad && LATENCY > 1) nextState = WAIT;
            WAIT:    if (count == CNT_W'(1)) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        presentLoad = 1'b0;
        storeEn     = 1'b0;
        storeMis    = 1'b0;
        case (state)
            IDLE: begin
                if (MemWrite) begin
                    storeEn  = !liveMis;
                    storeMis = liveMis;
                end else if (MemRead && LATENCY == 1) begin
                    presentLoad = 1'b1;
                end
            end
            WAIT:    presentLoad = (count == CNT_W'(1));
            default: presentLoad = 1'b0;
        endcase
    end

    // Output registers, latency counter and latched load request.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ReadData   <= '0;
            ReadValid  <= 1'b0;
            Busy       <= 1'b0;
            Misaligned <= 1'b0;
            count      <= '0;
            ldIdx      <= '0;
            ldOffset   <= '0;
            ldSize     <= '0;
            ldUnsigned <= 1'b0;
            ldMis      <= 1'b0;
        end else begin
            ReadValid  <= presentLoad;
            Misaligned <= presentLoad ? selMis : storeMis;
            Busy       <= (nextState == WAIT);
            if (presentLoad) ReadData <= selMis ? 32'd0 : loadData_c;
            if (reqLoad) begin
                count      <= CNT_W'(LATENCY - 1);
                ldIdx      <= liveIdx;
                ldOffset   <= liveOffset;
                ldSize     <= Size;
                ldUnsigned <= Unsigned;
                ldMis      <= liveMis;
            end else if (state == WAIT) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage is never cleared by reset; stores during reset are dropped.
    always_ff @(posedge Clk) begin
        if (storeEn && !Reset) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn_c[i]) mem[liveIdx][8*i +: 8] <= storeWord_c[8*i +: 8];
            end
        end
    end

endmodule
